// File: rtl/macc_loader_if.sv
// rtl/macc_loader_if.sv - stream and matrix-port bundle between macc_loader and its neighbours
interface macc_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [2:0]        wen;
  logic [2:0]        ren;
  logic [DATA_W-1:0] mat_wdata;
  logic [DATA_W-1:0] mat_rdata_a;
  logic [DATA_W-1:0] mat_rdata_b;
  logic [DATA_W-1:0] mat_rdata_c;

  modport master (
    input  s_data, s_valid, m_ready, mat_rdata_a, mat_rdata_b, mat_rdata_c,
    output s_ready, m_data, m_valid, wen, ren, mat_wdata
  );

  modport slave (
    output s_data, s_valid, m_ready, mat_rdata_a, mat_rdata_b, mat_rdata_c,
    input  s_ready, m_data, m_valid, wen, ren, mat_wdata
  );
endinterface

// File: rtl/macc_loader.sv
// rtl/macc_loader.sv - stream-to-matrix load sequencer; readback path under MACC_LOADER_READBACK_EN
module macc_loader #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             mode,
  input  logic [1:0]       mat_sel,
  input  logic [IDX_W-1:0] max_col,
  input  logic [IDX_W-1:0] max_row,
  macc_loader_if.master    bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
`ifdef MACC_LOADER_READBACK_EN
    READ = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        sel;
  logic [IDX_W-1:0]  col, row, lim_col, lim_row;
  logic [IDX_W-1:0]  col_nxt, row_nxt;
  logic              s_ready_r;
  logic [2:0]        wen_r;
  logic [DATA_W-1:0] wdata_r;
  logic [2:0]        sel_oh;
  logic              last;
  logic              hs;
  logic              start_bad;

  assign sel_oh = 3'b100 >> sel;
  assign last   = (row == lim_row) && (col == lim_col);
  assign hs     = s_ready_r & bus.s_valid;

  always_comb begin
    col_nxt = col + 1'b1;
    row_nxt = row;
    if (col == lim_col) begin
      col_nxt = '0;
      row_nxt = row + 1'b1;
    end
  end

`ifdef MACC_LOADER_READBACK_EN
  logic              rd_all;
  logic              ren_q;
  logic [1:0]        fcnt;
  logic [DATA_W-1:0] f0, f1;
  logic [DATA_W-1:0] rdata;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;

  assign start_bad = (mat_sel == 2'd3);
  assign pop       = (fcnt != 2'd0) & bus.m_ready;
  assign occ       = {1'b0, fcnt} + {2'b00, ren_q};

  // Read strobe depends on this cycle's pop so the 2-entry FIFO sustains one element per cycle.
  always_comb begin
    issue = (state == READ) && !rd_all && (occ < (3'd2 + {2'b00, pop}));
    case (sel)
      2'd0:    rdata = bus.mat_rdata_a;
      2'd1:    rdata = bus.mat_rdata_b;
      default: rdata = bus.mat_rdata_c;
    endcase
  end

  assign bus.ren     = issue ? sel_oh : 3'b000;
  assign bus.m_valid = (fcnt != 2'd0);
  assign bus.m_data  = f0;
`else
  logic unused_rb;

  assign start_bad   = (mat_sel == 2'd3) | mode;
  assign unused_rb   = ^{bus.m_ready, bus.mat_rdata_a, bus.mat_rdata_b, bus.mat_rdata_c};
  assign bus.ren     = 3'b000;
  assign bus.m_valid = 1'b0;
  assign bus.m_data  = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      sel       <= 2'd0;
      col       <= '0;
      row       <= '0;
      lim_col   <= '0;
      lim_row   <= '0;
      s_ready_r <= 1'b0;
      wen_r     <= 3'b000;
      wdata_r   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MACC_LOADER_READBACK_EN
      rd_all    <= 1'b0;
      ren_q     <= 1'b0;
      fcnt      <= 2'd0;
      f0        <= '0;
      f1        <= '0;
`endif
    end else begin
      wen_r <= 3'b000;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_bad) begin
              err <= 1'b1;
            end else begin
              sel     <= mat_sel;
              lim_col <= max_col;
              lim_row <= max_row;
              col     <= '0;
              row     <= '0;
              busy    <= 1'b1;
`ifdef MACC_LOADER_READBACK_EN
              rd_all  <= 1'b0;
              if (mode) begin
                state <= READ;
              end else begin
                state     <= LOAD;
                s_ready_r <= 1'b1;
              end
`else
              state     <= LOAD;
              s_ready_r <= 1'b1;
`endif
            end
          end
        end
        LOAD: begin
          if (hs) begin
            wen_r   <= sel_oh;
            wdata_r <= bus.s_data;
            col     <= col_nxt;
            row     <= row_nxt;
            if (last) begin
              state     <= DONE;
              s_ready_r <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
`ifdef MACC_LOADER_READBACK_EN
        READ: begin
          if (issue) begin
            col <= col_nxt;
            row <= row_nxt;
            if (last) rd_all <= 1'b1;
          end
          // Final pop: everything issued, nothing in flight, one entry left.
          if (rd_all && pop && (fcnt == 2'd1) && !ren_q) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
`ifdef MACC_LOADER_READBACK_EN
      ren_q <= issue;
      case ({ren_q, pop})
        2'b10: begin
          if (fcnt == 2'd0) f0 <= rdata;
          else              f1 <= rdata;
          fcnt <= fcnt + 2'd1;
        end
        2'b01: begin
          f0   <= f1;
          fcnt <= fcnt - 2'd1;
        end
        2'b11: begin
          if (fcnt == 2'd1) begin
            f0 <= rdata;
          end else begin
            f0 <= f1;
            f1 <= rdata;
          end
        end
        default: ;
      endcase
`endif
    end
  end

  assign bus.s_ready   = s_ready_r;
  assign bus.wen       = wen_r;
  assign bus.mat_wdata = wdata_r;

endmodule

// File: tb/tb_macc_loader.sv
// tb/tb_macc_loader.sv - randomized self-checking bench for macc_loader against a transaction-level model
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_macc_loader;
  localparam int DW = 32;
  localparam int IW = 10;
`ifdef MACC_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [1:0]    mat_sel = 2'd0;
  logic [IW-1:0] max_col = '0;
  logic [IW-1:0] max_row = '0;
  logic          busy, done, err;

  macc_loader_if #(.DATA_W(DW)) bus();

  macc_loader #(.DATA_W(DW), .IDX_W(IW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .mat_sel(mat_sel),
    .max_col(max_col), .max_row(max_row), .bus(bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] base(logic [1:0] s);
    case (s)
      2'd0:    return 32'h1000;
      2'd1:    return 32'h2000;
      default: return 32'h00A0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(logic [1:0] s);
    case (s)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Transaction-level model: phase 0 idle, 1 loading, 2 reading back, 3 finishing.
  int          e_phase = 0;
  logic [2:0]  e_wen = 3'b000;
  logic        e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_wdata = 32'h0;
  logic [1:0]  e_sel = 2'd0;
  int          e_total = 0, e_left = 0, e_popped = 0, e_issued = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev = 32'h0;
  logic        mon_pop;
  logic [2:0]  rd_bits = 3'b000;
  logic [31:0] rd_val = 32'h0;
  int          cnt_done = 0, cnt_err = 0, cnt_ren = 0;
  logic [31:0] wlog[$];
  logic [2:0]  wenlog[$];
  logic        donelog[$];
  logic [31:0] mlog[$];

  // Matrix memories: element i of matrix s reads as base(s)+i one cycle after its strobe, noise otherwise.
  always @(posedge CLK) begin
    bus.mat_rdata_a <= rd_bits[2] ? rd_val : $urandom;
    bus.mat_rdata_b <= rd_bits[1] ? rd_val : $urandom;
    bus.mat_rdata_c <= rd_bits[0] ? rd_val : $urandom;
  end

  always @(negedge CLK) begin
    `CHK("busy", busy, e_phase != 0);
    `CHK("s_ready", bus.s_ready, e_phase == 1);
    `CHK("wen", bus.wen, e_wen);
    `CHK("mat_wdata", bus.mat_wdata, e_wdata);
    `CHK("done", done, e_done);
    `CHK("err", err, e_err);
    mon_pop = bus.m_valid & bus.m_ready;
    rd_bits = 3'b000;
    if (e_phase != 2) begin
      `CHK("ren_idle", bus.ren, 3'b000);
      `CHK("m_valid_idle", bus.m_valid, 1'b0);
    end else begin
      if (bus.ren != 3'b000) begin
        `CHK("ren_sel", bus.ren, onehot(e_sel));
        rd_bits = bus.ren;
        rd_val  = base(e_sel) + e_issued;
        e_issued++;
      end
      `CHK("ren_total", e_issued <= e_total, 1'b1);
      if (stall_prev) begin
        `CHK("m_hold_valid", bus.m_valid, 1'b1);
        `CHK("m_hold_data", bus.m_data, data_prev);
      end
      if (mon_pop) begin
        `CHK("m_data", bus.m_data, base(e_sel) + e_popped);
        mlog.push_back(bus.m_data);
        e_popped++;
      end
      `CHK("fifo_occ", (e_issued - e_popped) <= 2, 1'b1);
    end
    if (bus.wen != 3'b000) begin
      wlog.push_back(bus.mat_wdata);
      wenlog.push_back(bus.wen);
      donelog.push_back(done);
    end
    if (done) cnt_done++;
    if (err) cnt_err++;
    if (bus.ren != 3'b000) cnt_ren++;

    stall_prev = !RST && (e_phase == 2) && bus.m_valid && !bus.m_ready;
    data_prev  = bus.m_data;
    e_wen  = 3'b000;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (RST) begin
      e_phase = 0;
      e_wdata = 32'h0;
    end else begin
      case (e_phase)
        0: if (start) begin
          if (mat_sel == 2'd3 || (mode && !RB)) begin
            e_err = 1'b1;
          end else begin
            e_sel    = mat_sel;
            e_total  = (int'(max_row) + 1) * (int'(max_col) + 1);
            e_left   = e_total;
            e_popped = 0;
            e_issued = 0;
            e_phase  = mode ? 2 : 1;
          end
        end
        1: if (bus.s_valid) begin
          e_wen   = onehot(e_sel);
          e_wdata = bus.s_data;
          e_left--;
          if (e_left == 0) begin
            e_phase = 3;
            e_done  = 1'b1;
          end
        end
        2: if (mon_pop && e_popped == e_total) begin
          e_phase = 3;
          e_done  = 1'b1;
        end
        default: e_phase = 0;
      endcase
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic kick(logic [1:0] s, logic md, int mc, int mr);
    start   = 1'b1;
    mat_sel = s;
    mode    = md;
    max_col = IW'(mc);
    max_row = IW'(mr);
    cyc();
    start   = 1'b0;
    mat_sel = 2'($urandom);
    mode    = 1'($urandom);
    max_col = IW'($urandom);
    max_row = IW'($urandom);
  endtask

  task automatic wait_idle(string nm, int lim);
    int n = 0;
    while (busy === 1'b1 && n < lim) begin
      cyc();
      n++;
    end
    `CHK(nm, busy, 1'b0);
  endtask

  initial begin
    int w0, e0, r0, m0, d0;
    logic [6:0] pat;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    bus.m_ready = 1'b0;
    cyc(3);
    `CHK("rst_busy", busy, 1'b0);
    `CHK("rst_s_ready", bus.s_ready, 1'b0);
    `CHK("rst_m_valid", bus.m_valid, 1'b0);
    `CHK("rst_wen", bus.wen, 3'b000);
    `CHK("rst_ren", bus.ren, 3'b000);
    `CHK("rst_m_data", bus.m_data, 32'h0);
    `CHK("rst_mat_wdata", bus.mat_wdata, 32'h0);
    `CHK("rst_done_err", {done, err}, 2'b00);
    RST = 1'b0;
    cyc();

    // Load B, 2x2, back-to-back handshakes.
    w0 = wlog.size();
    kick(2'd1, 1'b0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h10 + i;
      cyc();
    end
    bus.s_valid = 1'b0;
    `CHK("t1_done", done, 1'b1);
    `CHK("t1_wen_last", bus.wen, 3'b010);
    cyc();
    `CHK("t1_busy_after", busy, 1'b0);
    `CHK("t1_nwrites", wlog.size() - w0, 4);
    for (int i = 0; i < 4 && (w0 + i) < wlog.size(); i++) begin
      `CHK($sformatf("t1_wdata%0d", i), wlog[w0 + i], 32'h10 + i);
      `CHK($sformatf("t1_wen%0d", i), wenlog[w0 + i], 3'b010);
      `CHK($sformatf("t1_done%0d", i), donelog[w0 + i], i == 3);
    end

    // Load A, 3x1, valid toggling 1,0,1,0,1.
    w0 = wlog.size();
    kick(2'd0, 1'b0, 2, 0);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = (i % 2 == 0);
      bus.s_data  = $urandom;
      cyc();
    end
    bus.s_valid = 1'b0;
    wait_idle("t2_idle", 20);
    `CHK("t2_nwrites", wlog.size() - w0, 3);

    // Illegal select, then a start while busy.
    e0 = cnt_err;
    kick(2'd3, 1'b0, 0, 0);
    `CHK("t3_err", err, 1'b1);
    `CHK("t3_busy", busy, 1'b0);
    cyc();
    `CHK("t3_err_once", err, 1'b0);
    kick(2'd2, 1'b0, 1, 0);
    cyc();
    start = 1'b1; mat_sel = 2'd3; cyc();
    mat_sel = 2'd0; mode = 1'b0; cyc();
    start = 1'b0;
    `CHK("t3_still_loading", bus.s_ready, 1'b1);
    bus.s_valid = 1'b1; bus.s_data = 32'hCAFE; cyc(2);
    bus.s_valid = 1'b0;
    wait_idle("t3_idle", 20);
    `CHK("t3_err_count", cnt_err - e0, 1);

    r0 = cnt_ren;
`ifdef MACC_LOADER_READBACK_EN
    // Readback C, 2x2, with a stalling consumer.
    m0  = mlog.size();
    pat = 7'b1011001;
    kick(2'd2, 1'b1, 1, 1);
    for (int i = 0; i < 7; i++) begin
      bus.m_ready = pat[i];
      cyc();
    end
    bus.m_ready = 1'b1;
    wait_idle("t4_idle", 50);
    `CHK("t4_nreads", mlog.size() - m0, 4);
    for (int i = 0; i < 4 && (m0 + i) < mlog.size(); i++)
      `CHK($sformatf("t4_mdata%0d", i), mlog[m0 + i], 32'hA0 + i);
    `CHK("t4_ren_count", cnt_ren - r0, 4);
`else
    e0 = cnt_err;
    kick(2'd2, 1'b1, 1, 1);
    `CHK("t4_err", err, 1'b1);
    `CHK("t4_busy", busy, 1'b0);
    cyc(3);
    `CHK("t4_err_count", cnt_err - e0, 1);
    `CHK("t4_ren_count", cnt_ren - r0, 0);
`endif

    // Reset in the middle of a 4x4 load, then a 1x1 load.
    kick(2'd0, 1'b0, 3, 3);
    bus.s_valid = 1'b1;
    cyc(5);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    bus.s_valid = 1'b0;
    `CHK("t5_busy", busy, 1'b0);
    `CHK("t5_s_ready", bus.s_ready, 1'b0);
    `CHK("t5_wen", bus.wen, 3'b000);
    `CHK("t5_done", done, 1'b0);
    `CHK("t5_mat_wdata", bus.mat_wdata, 32'h0);
    d0 = cnt_done;
    w0 = wlog.size();
    kick(2'd1, 1'b0, 0, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h55;
    cyc();
    bus.s_valid = 1'b0;
    `CHK("t5_wen_single", bus.wen, 3'b010);
    `CHK("t5_done_single", done, 1'b1);
    `CHK("t5_wdata_single", bus.mat_wdata, 32'h55);
    wait_idle("t5_idle", 10);
    `CHK("t5_nwrites", wlog.size() - w0, 1);
    `CHK("t5_ndone", cnt_done - d0, 1);

    // Random traffic: starts (legal and illegal), stalls, changing limits, rare resets.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      mat_sel = 2'($urandom);
      mode    = 1'($urandom);
      if (start) begin
        max_col = IW'($urandom_range(0, 3));
        max_row = IW'($urandom_range(0, 3));
      end else begin
        max_col = IW'($urandom);
        max_row = IW'($urandom);
      end
      bus.s_valid = 1'($urandom);
      bus.s_data  = $urandom;
      bus.m_ready = 1'($urandom);
      RST = ($urandom_range(0, 499) == 0);
      cyc();
    end
    start = 1'b0;
    RST = 1'b0;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    wait_idle("final_idle", 200);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/macc_loader.md
# macc_loader

Stream-to-matrix sequencer sitting directly upstream of the matrix accelerator top. It accepts 32-bit words on a valid/ready input stream and converts each accepted word into a one-cycle write strobe plus data for the selected matrix (A, B or C), tracking row/column position so a transfer ends exactly at the matrix boundary. Optionally it also runs the reverse path: it issues read strobes, captures matrix read data and presents it on a valid/ready output stream.

## Interface
Parameters:
- DATA_W, 32, word width of streams and matrix data.
- IDX_W, 10, width of row/column index and limit inputs.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
- mode  in  1  0 = load (stream → matrix), 1 = readback (matrix → stream).
- mat_sel  in  2  0 = A, 1 = B, 2 = C; 3 is illegal.
- max_col  in  IDX_W  last column index, inclusive.
- max_row  in  IDX_W  last row index, inclusive.
- s_data  in  DATA_W  input stream data.
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- m_data  out  DATA_W  output stream data.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- wen  out  3  one-hot write strobe: bit2 = A, bit1 = B, bit0 = C.
- ren  out  3  one-hot read strobe, same bit mapping.
- mat_wdata  out  DATA_W  write data, shared by all three matrices.
- mat_rdata_a / mat_rdata_b / mat_rdata_c  in  DATA_W each  matrix read data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at transfer end.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- **States:**
  - IDLE:
    - start with legal mat_sel → latch mat_sel, mode, max_col and max_row; clear row/col counters.
    - Go to LOAD (mode = 0) or READ (mode = 1).
    - start with mat_sel = 3 → err pulse next cycle, remain IDLE.
  - LOAD:
    - s_ready = 1.
    - Each handshake (s_valid & s_ready) registers s_data into mat_wdata and asserts the selected wen bit for exactly one cycle.
  - READ:
    - Issues the selected ren bit for one cycle per element.
    - Read data arrives the cycle after ren; it is captured from the selected mat_rdata into a 2-entry FIFO that drives m_data/m_valid.
    - ren is issued only when (FIFO occupancy + in-flight reads − pop this cycle) < 2.
  - DONE: done = 1 for one cycle, then IDLE.
- **Counters:**
  - col increments per element; at max_col it wraps to 0 and row increments.
  - The last element is row == max_row and col == max_col.
  - Element count is (max_row+1)·(max_col+1), from 1 up to 2^(2·IDX_W).
- **LOAD end:** the last handshake moves the FSM to DONE; s_ready drops in the same cycle that state is entered.
- **READ end:** after the last ren, no further ren is issued. DONE is entered after the last element handshakes on the output stream.
- **Ignored / not latched:**
  - start while busy is ignored, with no err.
  - Latched limits are not affected by input changes mid-transfer.
- **Output rules:**
  - At most one wen or ren bit is high in any cycle; wen and ren are never high together.
  - Reset mid-transfer: FSM to IDLE, counters and FIFO cleared, no done pulse.
- **Reset values:** s_ready, m_valid, wen, ren, busy, done and err are 0; m_data and mat_wdata are 0.

## Timing
- start in cycle 0 → busy = 1 and s_ready = 1 in cycle 1.
- Input handshake in cycle n → wen bit and mat_wdata valid in cycle n+1. Back-to-back handshakes give one write per cycle.
- For the final load handshake in cycle n:
  - done = 1 in cycle n+1, coinciding with the final wen.
  - busy = 0 in cycle n+2.
- Readback:
  - ren in cycle k → data sampled at the end of k+1 → m_valid with that data from cycle k+2.
  - Sustained throughput is one element per cycle while m_ready is held high.
- m_valid/m_data are stable while m_valid & !m_ready. No element is dropped or duplicated under any m_ready pattern.

## Configuration
- MACC_LOADER_READBACK_EN:
  - Defined: READ state, FIFO and ren logic are present as described.
  - Undefined:
    - READ is absent and ren, m_valid and m_data are tied to 0.
    - start with mode = 1 is rejected with an err pulse and stays IDLE.

## Test plan
- Load B with max_col = 1, max_row = 1, s_valid held high, data 0x10..0x13 → wen = 3'b010 on 4 consecutive cycles with mat_wdata 0x10, 0x11, 0x12, 0x13; done coincides with the 4th; busy low the following cycle.
- Load A with max_col = 2, max_row = 0, s_valid toggling 1,0,1,0,1 → exactly 3 wen = 3'b100 pulses, each one cycle after its handshake; no wen during gaps.
- start with mat_sel = 3 → err = 1 for one cycle, busy stays 0; a second start during a running load → ignored, no err.
- Readback C (MACC_LOADER_READBACK_EN defined), 2×2, mat_rdata_c model returning 0xA0+index, m_ready pattern 1,0,0,1,1,0,1 → m_data sequence 0xA0..0xA3 in order, no drops or duplicates, ren count = 4, FIFO never overflows.
- RST asserted in the middle of a 4×4 load → next cycle all outputs 0, state IDLE; a new 1×1 load then completes with a single wen pulse and a done pulse.
- MACC_LOADER_READBACK_EN undefined, start with mode = 1 → err pulse, ren stays 0.
